// File: rtl/fold_unit_arbiter.sv
// Round-robin arbiter that serialises NUM_REQ narrow requesters onto one shared
// fold/widen unit (op | op>>1, zero-extended) with a valid/ready result port.
module fold_unit_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 4,
    parameter  int OUT_W   = 24,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        out_valid,
    output logic [OUT_W-1:0]            out_data,
    output logic [ID_W-1:0]             out_id,
    input  logic                        out_ready,
    output logic                        busy,
    output logic [15:0]                 done_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_OUT
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     win_id;
    logic                win_found;
    int                  scan_idx;
    logic                accept;

    logic [DATA_W-1:0]   op_q;
    logic [ID_W-1:0]     id_q;
    logic [DATA_W-1:0]   fold_val;

    // Rotating priority search: the first valid requester at or after ptr wins.
    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(ptr) + k) % NUM_REQ;
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(scan_idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && state == ST_IDLE && win_found)
            req_ready[win_id] = 1'b1;
    end

    assign accept   = |(req_valid & req_ready);
    assign fold_val = op_q | (op_q >> 1);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)    state_next = ST_EXEC;
            ST_EXEC:                state_next = ST_OUT;
            ST_OUT:  if (out_ready) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            op_q       <= '0;
            id_q       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_id     <= '0;
            busy       <= 1'b0;
            done_count <= '0;
        end else begin
            busy <= (state_next != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q <= req_data[int'(win_id)*DATA_W +: DATA_W];
                        id_q <= win_id;
                        ptr  <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
                    end
                end
                ST_EXEC: begin
                    out_data  <= OUT_W'(fold_val);
                    out_id    <= id_q;
                    out_valid <= 1'b1;
                end
                ST_OUT: begin
                    // Result registers keep their last values after the handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (done_count != 16'hFFFF)
                            done_count <= done_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fold_unit_arbiter.sv
// Directed bench for fold_unit_arbiter: grant/latency, fold values, rotation,
// back-pressure, mid-flight reset and counter saturation.
module tb_fold_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [23:0] out_data;
    logic [1:0]  out_id;
    logic        out_ready;
    logic        busy;
    logic [15:0] done_count;

    int passed = 0;
    int total  = 0;
    logic [15:0] exp_done;
    logic [23:0] fair_fold [4];

    fold_unit_arbiter #(.NUM_REQ(4), .DATA_W(4), .OUT_W(24)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_ready  (out_ready),
        .busy       (busy),
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Single-requester transaction from IDLE with out_ready already 1; starts and ends at a negedge.
    task automatic run_one(input int id, input logic [3:0] op, input logic [23:0] exp_res);
        req_valid = 4'b0001 << id;
        req_data  = 16'h0;
        req_data[id*4 +: 4] = op;
        #1;
        chk("grant", {28'h0, req_ready}, 32'h1 << id);
        @(negedge clk);
        req_valid = 4'b0;
        req_data  = 16'hFFFF;
        #1;
        chk("exec_busy", {31'h0, busy}, 32'h1);
        chk("exec_no_valid", {31'h0, out_valid}, 32'h0);
        chk("exec_no_ready", {28'h0, req_ready}, 32'h0);
        @(negedge clk);
        chk("out_valid", {31'h0, out_valid}, 32'h1);
        chk("out_data", {8'h0, out_data}, {8'h0, exp_res});
        chk("out_id", {30'h0, out_id}, id);
        chk("upper_zero", {12'h0, out_data[23:4]}, 32'h0);
        @(negedge clk);
        exp_done = sat_inc(exp_done);
        chk("post_valid", {31'h0, out_valid}, 32'h0);
        chk("post_busy", {31'h0, busy}, 32'h0);
        chk("done_count", {16'h0, done_count}, {16'h0, exp_done});
        chk("data_hold", {8'h0, out_data}, {8'h0, exp_res});
    endtask

    initial begin
        fair_fold[0] = 24'h000001;
        fair_fold[1] = 24'h000003;
        fair_fold[2] = 24'h000003;
        fair_fold[3] = 24'h000006;

        // Reset values; req_ready must stay low while rst is high even with requests pending.
        rst = 1'b1; req_valid = 4'hF; req_data = 16'h4321; out_ready = 1'b0;
        exp_done = 16'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", {28'h0, req_ready}, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data", {8'h0, out_data}, 32'h0);
        chk("rst_out_id", {30'h0, out_id}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {16'h0, done_count}, 32'h0);
        req_valid = 4'h0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;

        // Single request, then fold/width cases.
        run_one(2, 4'hA, 24'h00000F);
        run_one(0, 4'h8, 24'h00000C);
        run_one(1, 4'h9, 24'h00000D);
        run_one(3, 4'h1, 24'h000001);

        // Fairness from reset: grants rotate 0,1,2,3 with accepts exactly 3 cycles apart.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_done = 16'h0;
        #1;
        chk("fair_rst_done", {16'h0, done_count}, 32'h0);
        req_valid = 4'hF;
        req_data  = 16'h4321;
        #1;
        for (int t = 0; t < 24; t++) begin
            chk("fair_grant", {28'h0, req_ready}, (t % 3 == 0) ? (32'h1 << ((t / 3) % 4)) : 32'h0);
            if (t % 3 == 2) begin
                chk("fair_id", {30'h0, out_id}, (t / 3) % 4);
                chk("fair_data", {8'h0, out_data}, {8'h0, fair_fold[(t / 3) % 4]});
                exp_done = sat_inc(exp_done);
            end
            @(negedge clk);
            #1;
        end
        chk("fair_done", {16'h0, done_count}, {16'h0, exp_done});

        // Back-pressure: requester 1 with operand 5 -> 7, others keep requesting throughout.
        req_valid = 4'b0010;
        req_data  = 16'h0050;
        out_ready = 1'b0;
        #1;
        chk("bp_grant", {28'h0, req_ready}, 32'h2);
        @(negedge clk);
        req_valid = 4'hF;
        req_data  = 16'hFFFF;
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("bp_valid", {31'h0, out_valid}, 32'h1);
            chk("bp_data", {8'h0, out_data}, 32'h7);
            chk("bp_id", {30'h0, out_id}, 32'h1);
            chk("bp_ready", {28'h0, req_ready}, 32'h0);
            chk("bp_busy", {31'h0, busy}, 32'h1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        exp_done = sat_inc(exp_done);
        #1;
        chk("bp_release_valid", {31'h0, out_valid}, 32'h0);
        chk("bp_release_busy", {31'h0, busy}, 32'h0);
        chk("bp_done", {16'h0, done_count}, {16'h0, exp_done});
        chk("bp_next_grant", {28'h0, req_ready}, 32'h4);
        req_valid = 4'h0;
        @(negedge clk);

        // Reset while in EXEC: operand 9 from requester 2 must be discarded.
        req_valid = 4'b0100;
        req_data  = 16'h0900;
        #1;
        chk("rx_grant", {28'h0, req_ready}, 32'h4);
        @(negedge clk);
        req_valid = 4'h0;
        rst = 1'b1;
        #1;
        chk("rx_rst_ready", {28'h0, req_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        exp_done = 16'h0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("rx_no_valid", {31'h0, out_valid}, 32'h0);
            chk("rx_busy", {31'h0, busy}, 32'h0);
            chk("rx_data", {8'h0, out_data}, 32'h0);
            chk("rx_id", {30'h0, out_id}, 32'h0);
            chk("rx_done", {16'h0, done_count}, 32'h0);
            @(negedge clk);
        end
        req_valid = 4'hF;
        req_data  = 16'h4321;
        #1;
        chk("rx_next_grant", {28'h0, req_ready}, 32'h1);
        @(negedge clk);
        req_valid = 4'h0;
        @(negedge clk);
        chk("rx_out_id", {30'h0, out_id}, 32'h0);
        chk("rx_out_data", {8'h0, out_data}, 32'h1);
        @(negedge clk);
        exp_done = sat_inc(exp_done);
        chk("rx_done_after", {16'h0, done_count}, {16'h0, exp_done});

        // Saturation: preload the counter near the top, then complete three transactions.
        force dut.done_count = 16'hFFFD;
        @(negedge clk);
        release dut.done_count;
        exp_done = 16'hFFFD;
        @(negedge clk);
        chk("sat_preload", {16'h0, done_count}, 32'hFFFD);
        run_one(0, 4'h2, 24'h000003);
        run_one(1, 4'hF, 24'h00000F);
        run_one(2, 4'h4, 24'h000006);
        chk("sat_final", {16'h0, done_count}, 32'hFFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
